// File: rtl/can_pkg.sv
// Shared CAN frame types and sizes, used by both the receive and transmit paths.
package can_pkg;

    localparam int unsigned CAN_ID_W    = 29;
    localparam int unsigned CAN_MAX_LEN = 8;
    localparam int unsigned CAN_DATA_W  = 8 * CAN_MAX_LEN;
    localparam int unsigned CAN_LEN_W   = 4;

    typedef struct packed {
        logic [CAN_ID_W-1:0]   id;
        logic                  ide;
        logic [CAN_LEN_W-1:0]  len;
        logic [CAN_DATA_W-1:0] data;
        logic                  trunc;
    } can_frame_t;

endpackage

// File: rtl/can_frame_fifo.sv
// Frame FIFO of can_frame_t. The head is read combinationally.
// A push while full is still accepted when a pop happens in the same cycle.
module can_frame_fifo
    import can_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  can_frame_t din,
    output logic       accept,
    input  logic       pop,
    output can_frame_t dout,
    output logic       empty
);

    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    can_frame_t  r_mem [DEPTH];

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;

    // The MSB of each pointer tells full apart from empty.
    assign w_full  = (r_wptr == {~r_rptr[AW], r_rptr[AW-1:0]});
    assign w_empty = (r_wptr == r_rptr);
    assign w_pop   = pop & ~w_empty;
    assign w_push  = push & (~w_full | w_pop);

    assign accept = w_push;
    assign empty  = w_empty;
    assign dout   = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wptr[AW-1:0]] <= din;
                r_wptr                <= r_wptr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/can_rx_frame_assembler.sv
// Packs the CAN receive byte stream into whole frames and queues them
// for the host reader. Frames that arrive while the queue is full are dropped and counted.
module can_rx_frame_assembler
    import can_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned AW     = 2,
    parameter int unsigned DROP_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_valid,
    input  logic                  rx_last,
    input  logic [7:0]            rx_data,
    input  logic [CAN_ID_W-1:0]   rx_id,
    input  logic                  rx_ide,
    output logic                  frm_valid,
    input  logic                  frm_ready,
    output logic [CAN_ID_W-1:0]   frm_id,
    output logic                  frm_ide,
    output logic [CAN_LEN_W-1:0]  frm_len,
    output logic [CAN_DATA_W-1:0] frm_data,
    output logic                  frm_trunc,
    output logic [DROP_W-1:0]     drop_cnt,
    output logic                  overflow
);

    logic [CAN_DATA_W-1:0] r_asm_data;
    logic [CAN_LEN_W-1:0]  r_asm_cnt;
    logic                  r_asm_trunc;
    logic                  r_overflow;
    logic [DROP_W-1:0]     r_drop_cnt;

    logic                  w_cnt_full;
    logic                  w_complete;
    logic [CAN_DATA_W-1:0] w_shift_data;
    can_frame_t            w_frame;
    can_frame_t            w_head;
    logic                  w_accept;
    logic                  w_empty;

    assign w_cnt_full   = (r_asm_cnt == CAN_LEN_W'(CAN_MAX_LEN));
    assign w_complete   = rx_valid & rx_last;
    assign w_shift_data = {r_asm_data[CAN_DATA_W-9:0], rx_data};

    // The closing byte is counted unless the frame is already at maximum length.
    always_comb begin
        w_frame       = '0;
        w_frame.id    = rx_id;
        w_frame.ide   = rx_ide;
        w_frame.len   = w_cnt_full ? CAN_LEN_W'(CAN_MAX_LEN) : r_asm_cnt + CAN_LEN_W'(1);
        w_frame.data  = w_cnt_full ? r_asm_data : w_shift_data;
        w_frame.trunc = r_asm_trunc | w_cnt_full;
    end

    can_frame_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (w_complete),
        .din    (w_frame),
        .accept (w_accept),
        .pop    (frm_ready),
        .dout   (w_head),
        .empty  (w_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_asm_data  <= '0;
            r_asm_cnt   <= '0;
            r_asm_trunc <= 1'b0;
            r_overflow  <= 1'b0;
            r_drop_cnt  <= '0;
        end else begin
            r_overflow <= w_complete & ~w_accept;
            if (w_complete && !w_accept && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + DROP_W'(1);
            end
            if (w_complete) begin
                r_asm_data  <= '0;
                r_asm_cnt   <= '0;
                r_asm_trunc <= 1'b0;
            end else if (rx_valid) begin
                if (w_cnt_full) begin
                    r_asm_trunc <= 1'b1;
                end else begin
                    r_asm_data <= w_shift_data;
                    r_asm_cnt  <= r_asm_cnt + CAN_LEN_W'(1);
                end
            end
        end
    end

    assign frm_valid = ~w_empty;
    assign frm_id    = w_head.id;
    assign frm_ide   = w_head.ide;
    assign frm_len   = w_head.len;
    assign frm_data  = w_head.data;
    assign frm_trunc = w_head.trunc;
    assign drop_cnt  = r_drop_cnt;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_can_rx_frame_assembler.sv
// Directed self-checking bench for can_rx_frame_assembler.
module tb_can_rx_frame_assembler;

    logic        clk;
    logic        rst;
    logic        rx_valid;
    logic        rx_last;
    logic [7:0]  rx_data;
    logic [28:0] rx_id;
    logic        rx_ide;
    logic        frm_valid;
    logic        frm_ready;
    logic [28:0] frm_id;
    logic        frm_ide;
    logic [3:0]  frm_len;
    logic [63:0] frm_data;
    logic        frm_trunc;
    logic [15:0] drop_cnt;
    logic        overflow;

    int n_checks = 0;
    int n_errors = 0;

    can_rx_frame_assembler #(
        .DEPTH  (4),
        .AW     (2),
        .DROP_W (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_last   (rx_last),
        .rx_data   (rx_data),
        .rx_id     (rx_id),
        .rx_ide    (rx_ide),
        .frm_valid (frm_valid),
        .frm_ready (frm_ready),
        .frm_id    (frm_id),
        .frm_ide   (frm_ide),
        .frm_len   (frm_len),
        .frm_data  (frm_data),
        .frm_trunc (frm_trunc),
        .drop_cnt  (drop_cnt),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic last, input logic [28:0] id, input logic ide);
        rx_valid = 1'b1;
        rx_data  = d;
        rx_last  = last;
        rx_id    = id;
        rx_ide   = ide;
        tick();
        rx_valid = 1'b0;
        rx_last  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        rst       = 1'b1;
        rx_valid  = 1'b0;
        rx_last   = 1'b0;
        rx_data   = 8'h00;
        rx_id     = 29'h0;
        rx_ide    = 1'b0;
        frm_ready = 1'b0;
        tick();
        tick();

        chk("rst_valid", 64'(frm_valid), 64'd0);
        chk("rst_id",    64'(frm_id),    64'd0);
        chk("rst_ide",   64'(frm_ide),   64'd0);
        chk("rst_len",   64'(frm_len),   64'd0);
        chk("rst_data",  frm_data,       64'd0);
        chk("rst_trunc", 64'(frm_trunc), 64'd0);
        chk("rst_drop",  64'(drop_cnt),  64'd0);
        chk("rst_ovf",   64'(overflow),  64'd0);
        rst = 1'b0;
        tick();

        // 8-byte standard frame
        frm_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            send(8'((i << 4) | i), (i == 8), 29'h123, 1'b0);
        end
        chk("f8_valid", 64'(frm_valid), 64'd1);
        chk("f8_data",  frm_data,       64'h1122334455667788);
        chk("f8_len",   64'(frm_len),   64'd8);
        chk("f8_id",    64'(frm_id),    64'h123);
        chk("f8_ide",   64'(frm_ide),   64'd0);
        chk("f8_trunc", 64'(frm_trunc), 64'd0);
        tick();
        chk("f8_popped", 64'(frm_valid), 64'd0);

        // 2-byte extended frame
        send(8'hAB, 1'b0, 29'h12345678, 1'b1);
        send(8'hCD, 1'b1, 29'h12345678, 1'b1);
        chk("f2_valid", 64'(frm_valid), 64'd1);
        chk("f2_data",  frm_data,       64'h000000000000ABCD);
        chk("f2_len",   64'(frm_len),   64'd2);
        chk("f2_ide",   64'(frm_ide),   64'd1);
        chk("f2_id",    64'(frm_id),    64'h12345678);
        tick();
        chk("f2_popped", 64'(frm_valid), 64'd0);

        // Overflow: five frames into a four-deep FIFO
        frm_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            send(8'(i), 1'b1, 29'h7, 1'b0);
            if (i == 4) chk("ovf_no_pulse_yet", 64'(overflow), 64'd0);
        end
        chk("ovf_pulse", 64'(overflow), 64'd1);
        chk("ovf_drop",  64'(drop_cnt), 64'd1);
        tick();
        chk("ovf_pulse_end", 64'(overflow), 64'd0);
        chk("ovf_drop_hold", 64'(drop_cnt), 64'd1);
        chk("ovf_hold_data", frm_data,      64'd1);
        frm_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("ovf_drain_valid", 64'(frm_valid), 64'd1);
            chk("ovf_drain_data",  frm_data,       64'(i));
            tick();
        end
        frm_ready = 1'b0;
        chk("ovf_empty", 64'(frm_valid), 64'd0);

        do_reset();
        chk("rst2_drop", 64'(drop_cnt), 64'd0);

        // Full FIFO, completion coincides with a pop
        for (int i = 1; i <= 4; i++) begin
            send(8'(i), 1'b1, 29'h9, 1'b0);
        end
        frm_ready = 1'b1;
        send(8'd5, 1'b1, 29'h9, 1'b0);
        frm_ready = 1'b0;
        chk("fp_no_ovf",  64'(overflow),  64'd0);
        chk("fp_drop",    64'(drop_cnt),  64'd0);
        chk("fp_valid",   64'(frm_valid), 64'd1);
        frm_ready = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            chk("fp_drain_data", frm_data, 64'(i));
            tick();
        end
        frm_ready = 1'b0;
        chk("fp_empty", 64'(frm_valid), 64'd0);

        // 10-byte frame truncates to 8
        for (int i = 1; i <= 10; i++) begin
            send(8'(i), (i == 10), 29'h55, 1'b0);
        end
        chk("tr_len",   64'(frm_len),   64'd8);
        chk("tr_data",  frm_data,       64'h0102030405060708);
        chk("tr_trunc", 64'(frm_trunc), 64'd1);
        send(8'h77, 1'b1, 29'h56, 1'b0);
        frm_ready = 1'b1;
        tick();
        frm_ready = 1'b0;
        chk("tr_next_valid", 64'(frm_valid), 64'd1);
        chk("tr_next_trunc", 64'(frm_trunc), 64'd0);
        chk("tr_next_len",   64'(frm_len),   64'd1);
        chk("tr_next_data",  frm_data,       64'h77);
        frm_ready = 1'b1;
        tick();
        frm_ready = 1'b0;
        chk("tr_empty", 64'(frm_valid), 64'd0);

        // Reset in the middle of a frame discards it
        send(8'hA1, 1'b0, 29'h33, 1'b0);
        send(8'hA2, 1'b0, 29'h33, 1'b0);
        send(8'hA3, 1'b0, 29'h33, 1'b0);
        rst = 1'b1;
        #1;
        chk("mr_valid_in_rst", 64'(frm_valid), 64'd0);
        tick();
        chk("mr_valid_in_rst2", 64'(frm_valid), 64'd0);
        rst = 1'b0;
        tick();
        chk("mr_valid_after", 64'(frm_valid), 64'd0);
        send(8'h5A, 1'b1, 29'h33, 1'b0);
        chk("mr_valid", 64'(frm_valid), 64'd1);
        chk("mr_len",   64'(frm_len),   64'd1);
        chk("mr_data",  frm_data,       64'h5A);
        chk("mr_trunc", 64'(frm_trunc), 64'd0);
        chk("mr_drop",  64'(drop_cnt),  64'd0);
        tick();
        chk("mr_hold_valid", 64'(frm_valid), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
